// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// Module   : ex_stage
// Purpose  : Pipeline execute stage: operand forwarding, ALU, iterative
//            shift-add multiplier and the EX/MEM pipeline register.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ID_EX_RegWrite_i,
  input  logic              ID_EX_MemRead_i,
  input  logic              ID_EX_MemWrite_i,
  input  logic              ID_EX_MemtoReg_i,
  input  logic              ID_EX_ALUSrc_i,
  input  logic              ID_EX_RegDst_i,
  input  logic [3:0]        ID_EX_ALUCtrl_i,
  input  logic [DATA_W-1:0] ID_EX_RsData_i,
  input  logic [DATA_W-1:0] ID_EX_RtData_i,
  input  logic [DATA_W-1:0] ID_EX_Imm_i,
  input  logic [4:0]        ID_EX_Shamt_i,
  input  logic [REG_W-1:0]  ID_EX_RegRt_i,
  input  logic [REG_W-1:0]  ID_EX_RegRd_i,
  input  logic [1:0]        ForwardA_i,
  input  logic [1:0]        ForwardB_i,
  input  logic [DATA_W-1:0] MEM_WB_WriteData_i,
  input  logic              flush_i,
  output logic              ex_stall_o,
  output logic              EX_MEM_RegWrite_o,
  output logic              EX_MEM_MemRead_o,
  output logic              EX_MEM_MemWrite_o,
  output logic              EX_MEM_MemtoReg_o,
  output logic [DATA_W-1:0] EX_MEM_ALUResult_o,
  output logic [DATA_W-1:0] EX_MEM_WriteData_o,
  output logic [REG_W-1:0]  EX_MEM_RegRd_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] c_ALU_AND = 4'd0;
  localparam logic [3:0] c_ALU_OR  = 4'd1;
  localparam logic [3:0] c_ALU_ADD = 4'd2;
  localparam logic [3:0] c_ALU_SLL = 4'd3;
  localparam logic [3:0] c_ALU_SUB = 4'd6;
  localparam logic [3:0] c_ALU_SLT = 4'd7;
  localparam logic [3:0] c_ALU_MUL = 4'd8;
  localparam logic [3:0] c_ALU_NOR = 4'd12;

  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mulState_t;

  mulState_t         r_state;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_fwdA;
  logic [DATA_W-1:0] w_fwdB;
  logic [DATA_W-1:0] w_opB;
  logic [REG_W-1:0]  w_dst;
  logic [DATA_W-1:0] w_aluResult;
  logic              w_isMul;
  logic              w_stall;

  // Forwarding muxes; codes 0 and 3 both select the register-file value.
  always_comb begin
    w_fwdA = ID_EX_RsData_i;
    case (ForwardA_i)
      2'd1:    w_fwdA = EX_MEM_ALUResult_o;
      2'd2:    w_fwdA = MEM_WB_WriteData_i;
      default: w_fwdA = ID_EX_RsData_i;
    endcase
  end

  always_comb begin
    w_fwdB = ID_EX_RtData_i;
    case (ForwardB_i)
      2'd1:    w_fwdB = EX_MEM_ALUResult_o;
      2'd2:    w_fwdB = MEM_WB_WriteData_i;
      default: w_fwdB = ID_EX_RtData_i;
    endcase
  end

  assign w_opB   = ID_EX_ALUSrc_i ? ID_EX_Imm_i : w_fwdB;
  assign w_dst   = ID_EX_RegDst_i ? ID_EX_RegRd_i : ID_EX_RegRt_i;
  assign w_isMul = (ID_EX_ALUCtrl_i == c_ALU_MUL);

  // The MUL result is only consumed in DONE, when the accumulator holds the product.
  always_comb begin
    w_aluResult = '0;
    case (ID_EX_ALUCtrl_i)
      c_ALU_AND: w_aluResult = w_fwdA & w_opB;
      c_ALU_OR:  w_aluResult = w_fwdA | w_opB;
      c_ALU_ADD: w_aluResult = w_fwdA + w_opB;
      c_ALU_SUB: w_aluResult = w_fwdA - w_opB;
      c_ALU_SLT: w_aluResult = ($signed(w_fwdA) < $signed(w_opB)) ?
                               DATA_W'(1) : '0;
      c_ALU_NOR: w_aluResult = ~(w_fwdA | w_opB);
      c_ALU_SLL: w_aluResult = w_opB << ID_EX_Shamt_i;
      c_ALU_MUL: w_aluResult = r_acc;
      default:   w_aluResult = '0;
    endcase
  end

  assign w_stall    = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_isMul);
  assign ex_stall_o = w_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isMul && !flush_i) begin
            r_mcand  <= w_fwdA;
            r_mplier <= w_opB;
            r_acc    <= '0;
            r_count  <= c_CNT_INIT;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
            if (r_count == c_CNT_LAST) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // EX/MEM register: a bubble is every field cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || w_stall) begin
      EX_MEM_RegWrite_o  <= 1'b0;
      EX_MEM_MemRead_o   <= 1'b0;
      EX_MEM_MemWrite_o  <= 1'b0;
      EX_MEM_MemtoReg_o  <= 1'b0;
      EX_MEM_ALUResult_o <= '0;
      EX_MEM_WriteData_o <= '0;
      EX_MEM_RegRd_o     <= '0;
    end else begin
      EX_MEM_RegWrite_o  <= ID_EX_RegWrite_i;
      EX_MEM_MemRead_o   <= ID_EX_MemRead_i;
      EX_MEM_MemWrite_o  <= ID_EX_MemWrite_i;
      EX_MEM_MemtoReg_o  <= ID_EX_MemtoReg_i;
      EX_MEM_ALUResult_o <= w_aluResult;
      EX_MEM_WriteData_o <= w_fwdB;
      EX_MEM_RegRd_o     <= w_dst;
    end
  end

endmodule

`default_nettype wire
